sha256_msg_schedule: RTL and testbench

//  Producer side of the W_t interface consumed by the SHA-256 round datapath.

---
 rtl/sha256_msg_schedule.sv | 133 +++++++++++++
 tb/tb_sha256_msg_schedule.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: accepts one 512-bit block and streams W0..W63 over a valid/ready port.
// Optional abort input is compiled in when SHA256_SCHED_ABORT_EN is defined.
module sha256_msg_schedule #(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [WIDTH-1:0] w_data,
    output logic [5:0]       w_idx,
    output logic             w_last,
    output logic             busy
`ifdef SHA256_SCHED_ABORT_EN
    ,
    input  logic             abort
`endif
);

    // state | meaning
    // IDLE  | window loaded or empty; waiting for a block (blk_ready=1)
    // RUN   | presenting win[0] as W_idx; each handshake slides the window

    generate
        if (WIDTH != 32) begin : g_bad_width
            $error("sha256_msg_schedule: WIDTH must be 32");
        end
        if (ROUNDS != 64) begin : g_bad_rounds
            $error("sha256_msg_schedule: ROUNDS must be 64");
        end
    endgenerate

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] win_q [16];
    logic [5:0]  idx_q;
    logic        load;
    logic        shift;
    logic        abort_hit;
    logic [31:0] w_next;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

`ifdef SHA256_SCHED_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // W_{t+16} from the current window; overflow wraps mod 2^32
    assign w_next = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_hit) begin
                    state_d = IDLE;
                end else if (w_ready) begin
                    shift = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else if (load) begin
            idx_q <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= blk_data[511 - 32*i -: 32];
            end
        end else if (shift) begin
            idx_q <= (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;
            for (int i = 0; i < 15; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[15] <= w_next;
        end else if (abort_hit && state_q == RUN) begin
            idx_q <= '0;
        end
    end

    // All outputs derive from registers only, so w_valid never sees w_ready combinationally
    assign blk_ready = (state_q == IDLE);
    assign w_valid   = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign w_data    = win_q[0];
    assign w_idx     = idx_q;
    assign w_last    = (state_q == RUN) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against an array-based SHA-256 schedule model.
// Covers reset, known vectors, random backpressure, back-to-back blocks and (with SHA256_SCHED_ABORT_EN) abort.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;
    logic         busy;
`ifdef SHA256_SCHED_ABORT_EN
    logic         abort = 1'b0;
`endif

    int           vectors = 0;
    int           errors = 0;
    logic [31:0]  exp_w [64];

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last),
        .busy      (busy)
`ifdef SHA256_SCHED_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule straight from the FIPS 180-4 recurrence
    task automatic build_exp(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            logic [31:0] s0, s1;
            s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
            s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
            exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Called at a negedge with blk_ready expected high; accepted at the following posedge
    task automatic send_block(input logic [511:0] b, input bit hold);
        check("blk_ready_before_send", 32'(blk_ready), 32'd1);
        blk_data  = b;
        blk_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) blk_valid = 1'b0;
    endtask

    // Consumes words 0..n-1 against exp_w; stalled cycles re-check the held word
    task automatic consume(input int n, input int ready_pct);
        int k = 0;
        int cycles = 0;
        while (k < n) begin
            @(negedge clk);
            cycles++;
            if (cycles > 64 * 40) begin
                check("consume_timeout", 32'(k), 32'(n));
                return;
            end
            check("w_valid", 32'(w_valid), 32'd1);
            check("busy", 32'(busy), 32'd1);
            check("blk_ready_run", 32'(blk_ready), 32'd0);
            check("w_idx", 32'(w_idx), 32'(k));
            check("w_data", w_data, exp_w[k]);
            check("w_last", 32'(w_last), 32'(k == 63));
            w_ready = ($urandom_range(0, 99) < ready_pct) ? 1'b1 : 1'b0;
            if (w_ready) k++;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        w_ready = 1'b0;
        check({tag, "_blk_ready"}, 32'(blk_ready), 32'd1);
        check({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_w_idx"}, 32'(w_idx), 32'd0);
    endtask

    task automatic full_block(input logic [511:0] b, input int ready_pct, input string tag);
        build_exp(b);
        send_block(b, 1'b0);
        consume(64, ready_pct);
        check_idle(tag);
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] blk_a;
        logic [511:0] blk_b;
        abc = {32'h61626380, {14{32'h0}}, 32'h00000018};

        repeat (3) @(negedge clk);
        check("rst_blk_ready", 32'(blk_ready), 32'd1);
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_w_last", 32'(w_last), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" with full throughput, plus the published early schedule words
        build_exp(abc);
        check("abc_w16_model", exp_w[16], 32'h61626380);
        check("abc_w17_model", exp_w[17], 32'h000F0000);
        full_block(abc, 100, "abc");

        full_block('0, 100, "zero");
        full_block(abc, 50, "abc_stall");
        for (int r = 0; r < 4; r++) full_block(rand_block(), $urandom_range(20, 100), "rand");

        // Back-to-back: second block held valid throughout the first block's run
        blk_a = rand_block();
        blk_b = rand_block();
        build_exp(blk_a);
        send_block(blk_a, 1'b1);
        blk_data = blk_b;
        consume(64, 70);
        @(negedge clk);
        w_ready = 1'b0;
        check("b2b_blk_ready", 32'(blk_ready), 32'd1);
        check("b2b_gap_w_valid", 32'(w_valid), 32'd0);
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        build_exp(blk_b);
        consume(64, 100);
        check_idle("b2b_end");

`ifdef SHA256_SCHED_ABORT_EN
        blk_a = rand_block();
        build_exp(blk_a);
        send_block(blk_a, 1'b0);
        consume(20, 100);
        @(negedge clk);
        check("abort_at_idx", 32'(w_idx), 32'd20);
        abort   = 1'b1;
        w_ready = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_idle("abort");
        // abort while idle must not block acceptance
        blk_b = rand_block();
        build_exp(blk_b);
        abort = 1'b1;
        send_block(blk_b, 1'b0);
        abort = 1'b0;
        consume(64, 60);
        check_idle("after_abort");
`endif

        // Asynchronous reset in the middle of a block
        blk_a = rand_block();
        build_exp(blk_a);
        send_block(blk_a, 1'b0);
        consume(10, 100);
        @(negedge clk);
        w_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_blk_ready", 32'(blk_ready), 32'd1);
        check("midrst_w_valid", 32'(w_valid), 32'd0);
        check("midrst_w_data", w_data, 32'd0);
        check("midrst_w_idx", 32'(w_idx), 32'd0);
        check("midrst_w_last", 32'(w_last), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_idle("post_rst");
        full_block(abc, 100, "post_rst_abc");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
